// File: rtl/full_adder_dataflow.sv
// Single-bit full adder cell, pure dataflow.
// Latency: combinational, zero cycles.
// Backpressure: none, no handshake at this level.
module full_adder_dataflow (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB first, one bit per clock through one full-adder cell.
// Latency: WIDTH+1 cycles from input handshake to out_valid; initiation interval WIDTH+2.
// Backpressure: result held in DONE while out_ready=0; in_ready stays low until released.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_co;

    // Ripple increment built from gates; the full-adder cell is the only adder here.
    function automatic logic [CW-1:0] incr(input logic [CW-1:0] v);
        logic          c;
        logic [CW-1:0] r;
        c = 1'b1;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

    full_adder_dataflow u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Next-state decode; unused encoding falls back to IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)        state_d = RUN;
            RUN:     if (count == LAST)   state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // State register plus operand shifters, carry, bit counter and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            count   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        count   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the top so bit 0 lands at sum[0] after WIDTH shifts.
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry_q <= fa_co;
                    count   <= incr(count);
                    if (count == LAST) begin
                        cout_q <= fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       rst4, in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0] a4, b4, sum4;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; hold = cycles out_ready stays low once out_valid is seen.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input int hold);
        logic [8:0] expv;
        int n;
        expv = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        chk("in_ready_idle", 64'(in_ready8), 64'(1));
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
        out_ready8 = (hold == 0);
        step();
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        n = 0;
        while (!out_valid8 && n < 40) begin
            chk("busy_run", 64'(busy8), 64'(1));
            chk("in_ready_run", 64'(in_ready8), 64'(0));
            step();
            n++;
        end
        chk("latency", 64'(n + 1), 64'(9));
        chk("sum", 64'(sum8), 64'(expv[7:0]));
        chk("cout", 64'(cout8), 64'(expv[8]));
        chk("busy_done", 64'(busy8), 64'(0));
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end else begin
                in_valid8 = 1'b0;
            end
            step();
            chk("bp_out_valid", 64'(out_valid8), 64'(1));
            chk("bp_in_ready", 64'(in_ready8), 64'(0));
            chk("bp_sum", 64'({cout8, sum8}), 64'(expv));
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        chk("in_ready_after_out", 64'(in_ready8), 64'(1));
        chk("out_valid_after_out", 64'(out_valid8), 64'(0));
        chk("sum_kept_idle", 64'({cout8, sum8}), 64'(expv));
    endtask

    initial begin
        logic [4:0] exp4;
        int n;
        int seen_valid;
        rst8 = 1'b1; rst4 = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        step();
        step();
        rst8 = 1'b0; rst4 = 1'b0;

        // Reset state.
        chk("rst_in_ready", 64'(in_ready8), 64'(1));
        chk("rst_out_valid", 64'(out_valid8), 64'(0));
        chk("rst_busy", 64'(busy8), 64'(0));
        chk("rst_sum", 64'(sum8), 64'(0));
        chk("rst_cout", 64'(cout8), 64'(0));
        chk("rst4_in_ready", 64'(in_ready4), 64'(1));

        // Directed WIDTH=8 vectors.
        run8(8'h5A, 8'h33, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 0);
        // Backpressure with an in_valid pulse while DONE.
        run8(8'hC3, 8'h7E, 1'b1, 5);

        // Reset on the third RUN cycle discards the operation.
        a8 = 8'hAA; b8 = 8'h77; cin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 64'(busy8), 64'(1));
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready8), 64'(1));
        chk("mid_rst_out_valid", 64'(out_valid8), 64'(0));
        chk("mid_rst_busy", 64'(busy8), 64'(0));
        chk("mid_rst_sum", 64'(sum8), 64'(0));
        chk("mid_rst_cout", 64'(cout8), 64'(0));
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid8) seen_valid++;
        end
        chk("no_valid_after_rst", 64'(seen_valid), 64'(0));
        run8(8'h10, 8'h20, 1'b1, 0);

        // Random WIDTH=8 operations with random backpressure.
        for (int i = 0; i < 24; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // WIDTH=4 exhaustive, in_valid held high back-to-back.
        out_ready4 = 1'b1;
        in_valid4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
            exp4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            n = 0;
            while (!in_ready4 && n < 10) begin
                step();
                n++;
            end
            chk("w4_in_ready", 64'(in_ready4), 64'(1));
            step();
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            n = 0;
            while (!out_valid4 && n < 20) begin
                chk("w4_in_ready_run", 64'(in_ready4), 64'(0));
                step();
                n++;
            end
            chk("w4_latency", 64'(n), 64'(4));
            chk("w4_in_ready_done", 64'(in_ready4), 64'(0));
            chk("w4_result", 64'({cout4, sum4}), 64'(exp4));
            step();
        end
        in_valid4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
